// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: req/ack handshake, store lane steering, load extension, bus timeout.
// Optional misalignment check enabled by defining MEM_ALIGN_CHK_EN (adds the align_err output).
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
`ifdef MEM_ALIGN_CHK_EN
   output logic        align_err,
`endif
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] OP_BU = 3'd1;
   localparam logic [2:0] OP_B  = 3'd2;
   localparam logic [2:0] OP_HU = 3'd3;
   localparam logic [2:0] OP_H  = 3'd4;

   localparam bit               TMO_EN   = (TIMEOUT != 32'd0);
   localparam logic [CNT_W-1:0] TMO_TERM = CNT_W'(TIMEOUT - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             we_r;
   logic [2:0]       op_r;
   logic [1:0]       addr_lo_r;
   logic             accept_s;
   logic             ack_done_s;
   logic             tmo_s;
   logic             mis_s;
   logic             mis_chk_s;
   logic             tmo_hit_s;

   function automatic logic [3:0] calc_be(input logic [2:0] op, input logic [1:0] a);
      logic [3:0] be;
      case (op)
         OP_BU, OP_B: be = 4'b0001 << a;
         OP_HU, OP_H: be = a[1] ? 4'b1100 : 4'b0011;
         default:     be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] calc_wdata(input logic [2:0] op, input logic [31:0] w);
      logic [31:0] d;
      case (op)
         OP_BU, OP_B: d = {4{w[7:0]}};
         OP_HU, OP_H: d = {2{w[15:0]}};
         default:     d = w;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] a,
                                            input logic [31:0] word);
      logic [31:0] sh;
      logic [15:0] hw;
      logic [31:0] r;
      sh = word >> {a, 3'b000};
      hw = a[1] ? word[31:16] : word[15:0];
      case (op)
         OP_B:    r = {{24{sh[7]}}, sh[7:0]};
         OP_BU:   r = {24'd0, sh[7:0]};
         OP_H:    r = {{16{hw[15]}}, hw};
         OP_HU:   r = {16'd0, hw};
         default: r = word;
      endcase
      return r;
   endfunction

`ifdef MEM_ALIGN_CHK_EN
   function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
      logic m;
      case (op)
         OP_BU, OP_B: m = 1'b0;
         OP_HU, OP_H: m = a[0];
         default:     m = (a != 2'b00);
      endcase
      return m;
   endfunction

   assign mis_chk_s = misaligned(req_op, req_addr[1:0]);
`else
   assign mis_chk_s = 1'b0;
`endif

   // Ack in the same cycle as the terminal count takes priority over the timeout.
   assign tmo_hit_s = TMO_EN && (cnt_r == TMO_TERM);

   // The pipeline advances in DONE; reset forces the stall low immediately.
   assign stall = ~reset & (((state_r == ST_IDLE) & req_valid) | (state_r == ST_BUSY));

   // Next-state and transition qualifiers
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      ack_done_s  = 1'b0;
      tmo_s       = 1'b0;
      mis_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid && mis_chk_s) begin
               state_nxt_s = ST_DONE;
               mis_s       = 1'b1;
            end else if (req_valid) begin
               state_nxt_s = ST_BUSY;
               accept_s    = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               state_nxt_s = ST_DONE;
               ack_done_s  = 1'b1;
            end else if (tmo_hit_s) begin
               state_nxt_s = ST_DONE;
               tmo_s       = 1'b1;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and BUSY-cycle counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_BUSY) && !mem_ack) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else if (state_r == ST_DONE) begin
            cnt_r <= {CNT_W{1'b0}};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Request fields needed after acceptance for load extension
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_r      <= 1'b0;
         op_r      <= 3'd0;
         addr_lo_r <= 2'b00;
      end else if (accept_s) begin
         we_r      <= req_we;
         op_r      <= req_op;
         addr_lo_r <= req_addr[1:0];
      end else begin
         we_r      <= we_r;
         op_r      <= op_r;
         addr_lo_r <= addr_lo_r;
      end
   end

   // Memory-side request outputs, launched on acceptance and held until ack or timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'b0000;
         mem_wdata <= 32'd0;
      end else if (accept_s) begin
         mem_req   <= 1'b1;
         mem_we    <= req_we;
         mem_addr  <= {req_addr[31:2], 2'b00};
         mem_be    <= calc_be(req_op, req_addr[1:0]);
         mem_wdata <= calc_wdata(req_op, req_wdata);
      end else if (ack_done_s || tmo_s) begin
         mem_req   <= 1'b0;
         mem_we    <= mem_we;
         mem_addr  <= mem_addr;
         mem_be    <= mem_be;
         mem_wdata <= mem_wdata;
      end else begin
         mem_req   <= mem_req;
         mem_we    <= mem_we;
         mem_addr  <= mem_addr;
         mem_be    <= mem_be;
         mem_wdata <= mem_wdata;
      end
   end

   // Response outputs: valid only during the DONE cycle, data zero otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= (state_nxt_s == ST_DONE);
         rsp_err   <= tmo_s | mis_s;
         if (ack_done_s && !we_r) begin
            rsp_rdata <= load_ext(op_r, addr_lo_r, mem_rdata);
         end else begin
            rsp_rdata <= 32'd0;
         end
      end
   end

`ifdef MEM_ALIGN_CHK_EN
   // Misalignment flag pulses alongside the error response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         align_err <= 1'b0;
      end else begin
         align_err <= mis_s;
      end
   end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT=4): directed accesses with a response scoreboard.
module tb_mem_access_ctrl;

   typedef struct packed {
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
`ifdef MEM_ALIGN_CHK_EN
   logic        align_err;
`endif
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int   passed = 0;
   int   failed = 0;
   int   total  = 0;
   exp_t sb_q[$];
   int   sc;
   int   rc;

   mem_access_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
`ifdef MEM_ALIGN_CHK_EN
      .align_err(align_err),
`endif
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response is compared against the oldest queued expectation.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_rdata", rsp_rdata, e.rdata);
            check("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic access(input string tag, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         output int stall_cnt, output int req_cnt);
      int   busy;
      int   exp_busy;
      bit   done;
      exp_t e;
      exp_busy = (waits < 0) ? 4 : waits + 1;
      @(posedge clk); #1;
      check({tag, "_idle_rsp"}, {31'd0, rsp_valid}, 32'd0);
      req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
      e.err = exp_err; e.rdata = exp_rdata;
      sb_q.push_back(e);
      #1;
      check({tag, "_accept_stall"}, {31'd0, stall}, 32'd1);
      stall_cnt = int'(stall);
      req_cnt = 0; busy = 0; done = 1'b0;
      while (!done && busy < 20) begin
         @(posedge clk); #1;
         if (rsp_valid === 1'b1) begin
            done = 1'b1;
         end else begin
            busy++;
            mem_ack = (busy == waits + 1);
            mem_rdata = rdata;
            #1;
            stall_cnt += int'(stall);
            req_cnt += int'(mem_req);
            if (busy == 1) begin
               check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
               check({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
               check({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
               check({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
               check({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            end
         end
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
      #1;
      check({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_done_mem_req"}, {31'd0, mem_req}, 32'd0);
      mem_ack = 1'b0;
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_be", {28'd0, mem_be}, 32'd0);
      reset = 1'b0;

      access("lb", 1'b0, 3'd2, 32'h0000_1002, 32'd0, 32'h0080_FF00, 0,
             4'b0100, 32'd0, 1'b0, 32'hFFFF_FF80, sc, rc);
      check("lb_stall_cycles", 32'(sc), 32'd2);

      access("lhu", 1'b0, 3'd3, 32'h0000_2002, 32'd0, 32'h8001_0000, 3,
             4'b1100, 32'd0, 1'b0, 32'h0000_8001, sc, rc);
      check("lhu_stall_cycles", 32'(sc), 32'd5);

      access("sb", 1'b1, 3'd2, 32'h0000_3003, 32'h1234_56AB, 32'hFFFF_FFFF, 1,
             4'b1000, 32'hABAB_ABAB, 1'b0, 32'd0, sc, rc);

      access("tmo", 1'b0, 3'd0, 32'h0000_4000, 32'd0, 32'h5555_5555, -1,
             4'b1111, 32'd0, 1'b1, 32'd0, sc, rc);
      check("tmo_req_cycles", 32'(rc), 32'd4);

      access("ack_at_tc", 1'b0, 3'd0, 32'h0000_4004, 32'd0, 32'hDEAD_BEEF, 3,
             4'b1111, 32'd0, 1'b0, 32'hDEAD_BEEF, sc, rc);

      access("lh", 1'b0, 3'd4, 32'h0000_5000, 32'd0, 32'h1234_8765, 0,
             4'b0011, 32'd0, 1'b0, 32'hFFFF_8765, sc, rc);

      access("lbu", 1'b0, 3'd1, 32'h0000_6001, 32'd0, 32'h0000_F100, 2,
             4'b0010, 32'd0, 1'b0, 32'h0000_00F1, sc, rc);

      access("sh", 1'b1, 3'd4, 32'h0000_7002, 32'hAAAA_5A5B, 32'd0, 0,
             4'b1100, 32'h5A5B_5A5B, 1'b0, 32'd0, sc, rc);

      access("sw", 1'b1, 3'd0, 32'h0000_8000, 32'hCAFE_F00D, 32'd0, 0,
             4'b1111, 32'hCAFE_F00D, 1'b0, 32'd0, sc, rc);

      access("op6_w", 1'b0, 3'd6, 32'h0000_9000, 32'd0, 32'h89AB_CDEF, 1,
             4'b1111, 32'd0, 1'b0, 32'h89AB_CDEF, sc, rc);

      // Reset during BUSY aborts the access without a response.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_B000;
      @(posedge clk); #1;
      check("abort_busy_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_mem_req", {31'd0, mem_req}, 32'd0);
      check("abort_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      req_valid = 1'b0;
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

      access("after_abort", 1'b0, 3'd2, 32'h0000_C001, 32'd0, 32'h0000_7F00, 0,
             4'b0010, 32'd0, 1'b0, 32'h0000_007F, sc, rc);

`ifdef MEM_ALIGN_CHK_EN
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_op = 3'd0; req_addr = 32'h0000_A001;
      sb_q.push_back('{err: 1'b1, rdata: 32'd0});
      #1;
      check("mis_accept_stall", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      check("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("mis_align_err", {31'd0, align_err}, 32'd1);
      check("mis_mem_req", {31'd0, mem_req}, 32'd0);
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("mis_align_clr", {31'd0, align_err}, 32'd0);
`else
      access("lw_unaligned", 1'b0, 3'd0, 32'h0000_A003, 32'd0, 32'h1122_3344, 0,
             4'b1111, 32'd0, 1'b0, 32'h1122_3344, sc, rc);
      access("lh_odd", 1'b0, 3'd4, 32'h0000_A003, 32'd0, 32'hF00D_0000, 0,
             4'b1100, 32'd0, 1'b0, 32'hFFFF_F00D, sc, rc);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every data-memory access issued by the MEM stage over a req/ack handshake to a variable-latency data memory.
- Stores: generates byte enables and replicated write data for SW/SH/SB.
- Loads: captures the read word and applies LW/LB/LBU/LH/LHU byte/half select and extension.
- Stalls the pipeline until the access completes. A bus timeout converts a hung access into an error response.

Parameters:
- TIMEOUT, 16: max BUSY cycles waiting for mem_ack before error response; 0 disables the timeout.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM stage has a load/store
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  0 W, 1 BU, 2 B, 3 HU, 4 H; 5-7 treated as W; stores ignore signedness
- req_addr  in  32  byte address
- req_wdata  in  32  store data (low byte/half used for SB/SH)
- stall  out  1  freeze the pipeline
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  error qualifier on rsp_valid
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  memory write
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  replicated store data
- mem_ack  in  1  memory done; mem_rdata valid the same cycle
- mem_rdata  in  32  read word

Behaviour:
- Reset (async, active-high) values: state=IDLE, counter=0. All outputs 0: stall, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Reset mid-access aborts immediately: mem_req drops asynchronously and no response is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On req_valid, latch we/op/addr/wdata and go to BUSY.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata are registered and valid from the first BUSY cycle.
- BUSY:
  - mem_req=1. mem_ack is sampled only in BUSY.
  - On mem_ack: capture the extended load data, go to DONE, drop mem_req.
  - Otherwise the counter increments. If TIMEOUT!=0 and counter==TIMEOUT-1 without ack, go to DONE with err=1 and rdata=0.
- DONE: rsp_valid=1 for exactly one cycle, then go to IDLE and clear the counter. req_valid is ignored in DONE; it is the request just completed.
- stall = (IDLE & req_valid) | BUSY. stall is combinational and is 0 in DONE, so the stage advances in the DONE cycle.
- Latency: ack in the first BUSY cycle gives rsp_valid 2 cycles after request acceptance. Each extra wait cycle adds 1.
- The requester holds all req_* fields stable while stall=1.
- Byte enables:
  - W: 1111.
  - H/HU: addr[1] ? 1100 : 0011.
  - B/BU: 0001 << addr[1:0].
  - mem_be=0 on loads is not required; loads drive the same mask.
- Store data:
  - W: wdata.
  - H: {2{wdata[15:0]}}.
  - B: {4{wdata[7:0]}}.
- Load extension:
  - W: the word.
  - B/BU: byte at addr[1:0].
  - H/HU: half at addr[1] (addr[1]=1 selects [31:16]).
  - B/H sign-extend; BU/HU zero-extend.
- Simultaneous ack and timeout terminal count: ack wins, err=0.
- Back-to-back requests: a new req_valid in the cycle after DONE is accepted normally.

Optional Feature:
- Macro: MEM_ALIGN_CHK_EN.
- Defined:
  - A misaligned request is one where W has addr[1:0]!=0, or H/HU has addr[0]!=0.
  - A misaligned request goes IDLE -> DONE directly, with no mem_req, rsp_err=1 and rsp_rdata=0.
  - An extra output align_err (1 bit, reset 0) pulses with rsp_valid for that case.
- Undefined: no alignment check and no align_err port. Word accesses ignore addr[1:0]; half accesses ignore addr[0].

Test Plan:
- LB, addr=0x...2, mem_rdata=0x0080FF00, ack in the first BUSY cycle -> mem_be=0100; rsp_rdata=0xFFFFFF80 two cycles after acceptance; stall high in IDLE(req) and BUSY, low in DONE.
- LHU, addr=0x...2, mem_rdata=0x80010000, ack after 3 wait cycles -> rsp_rdata=0x00008001; stall high for 5 cycles.
- SB, addr=0x...3, wdata=0x123456AB -> mem_we=1, mem_be=1000, mem_wdata=0xABABABAB; rsp_rdata=0, rsp_err=0.
- TIMEOUT=4, no ack -> mem_req high for 4 cycles then low; rsp_valid=1, rsp_err=1, rsp_rdata=0. Repeat with ack on the 4th BUSY cycle -> rsp_err=0.
- Reset asserted during BUSY -> mem_req and stall drop immediately, no rsp_valid. Next request completes normally.
- With MEM_ALIGN_CHK_EN: LW addr=0x...1 -> mem_req never asserts; rsp_err=1 and align_err=1 one cycle after acceptance.
